// File: rtl/mul_div_seq.sv
// Iterative RISC-V M-extension multiply/divide unit: one shift-add or restoring
// subtract step per cycle, identical WIDTH+1 cycle latency for every operation.
module mul_div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             flush,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] result
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned AW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX, OUT} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic             neg_q, neg_d;
  logic             sa_q, sa_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  logic             accept;
  logic             a_signed, b_signed, sgn_a, sgn_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, div_trial;
  logic [AW-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix, fix_res;

  // Operand signedness and magnitudes of the incoming request
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op)
      3'b001, 3'b100, 3'b110: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'b010:  a_signed = 1'b1;
      default: ;
    endcase
    sgn_a = a_signed & in_a[WIDTH-1];
    sgn_b = b_signed & in_b[WIDTH-1];
    mag_a = sgn_a ? (~in_a + WIDTH'(1)) : in_a;
    mag_b = sgn_b ? (~in_b + WIDTH'(1)) : in_b;
  end

  // acc holds {hi, lo} of the product, or {remainder, quotient/dividend}
  always_comb begin
    mul_sum   = {1'b0, acc_q[AW-1:WIDTH]} + ({1'b0, opnd_q} & {(WIDTH+1){acc_q[0]}});
    div_trial = {acc_q[AW-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
    prod_fix  = neg_q ? (~acc_q + AW'(1)) : acc_q;
    quo_fix   = dz_q ? '1 : (neg_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0]);
    rem_fix   = sa_q ? (~acc_q[AW-1:WIDTH] + WIDTH'(1)) : acc_q[AW-1:WIDTH];
    if (!op_q[2]) begin
      fix_res = (op_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[AW-1:WIDTH];
    end else begin
      fix_res = op_q[1] ? rem_fix : quo_fix;
    end
  end

  assign accept = valid && !flush && (state_q == IDLE || state_q == OUT);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    sa_d     = sa_q;
    dz_d     = dz_q;
    result_d = result_q;
    case (state_q)
      IDLE: ;
      CALC: begin
        if (!op_q[2]) begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (div_trial[WIDTH]) begin
          acc_d = {acc_q[AW-2:0], 1'b0};
        end else begin
          acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIX: begin
        result_d = fix_res;
        state_d  = OUT;
      end
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d = CALC;
      cnt_d   = '0;
      op_d    = op;
      opnd_d  = op[2] ? mag_b : mag_a;
      acc_d   = op[2] ? {WIDTH'(0), mag_a} : {WIDTH'(0), mag_b};
      neg_d   = sgn_a ^ sgn_b;
      sa_d    = sgn_a;
      dz_d    = (in_b == '0);
    end
    // Cancel wins over everything and leaves the last result intact
    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
    busy_d  = (state_d == CALC) || (state_d == FIX);
    ready_d = (state_d == OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      sa_q     <= sa_d;
      dz_q     <= dz_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  assign busy   = busy_q;
  assign ready  = ready_q;
  assign result = result_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// Scoreboard bench for mul_div_seq: a 32-bit instance for most checks and an
// 8-bit instance for the narrow-width cases.
module tb_mul_div_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        valid, flush, busy, ready;
  logic [2:0]  op;
  logic [31:0] in_a, in_b, result;
  logic        valid8, flush8, busy8, ready8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, result8;

  mul_div_seq #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .valid(valid), .op(op), .in_a(in_a), .in_b(in_b),
    .flush(flush), .busy(busy), .ready(ready), .result(result)
  );

  mul_div_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .valid(valid8), .op(op8), .in_a(a8), .in_b(b8),
    .flush(flush8), .busy(busy8), .ready(ready8), .result(result8)
  );

  typedef struct {
    string       tag;
    logic [31:0] res;
    int unsigned cyc;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc;
  int          errors;
  int          checks;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference for the 32-bit instance, built on the simulator's own arithmetic
  function automatic logic [31:0] model32(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0]        p;
    logic signed [31:0] sa, sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'b000: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'b001: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'b010: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
      3'b011: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'b100: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Monitor: every ready pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk(e.tag, result, e.res);
        chk({e.tag, "_lat"}, cyc, e.cyc);
      end
    end
  end

  // Caller is at a falling edge with the DUT able to accept on the next rise
  task automatic issue(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    exp_t e;
    valid = 1'b1;
    op    = o;
    in_a  = a;
    in_b  = b;
    e.tag = tag;
    e.res = exp;
    e.cyc = cyc + 34;
    sb_q.push_back(e);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic start_nopush(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    valid = 1'b1;
    op    = o;
    in_a  = a;
    in_b  = b;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      chk("drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic issue8(input string tag, input logic [2:0] o, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp);
    int unsigned start;
    int          n;
    start  = cyc;
    valid8 = 1'b1;
    op8    = o;
    a8     = a;
    b8     = b;
    @(negedge clk);
    valid8 = 1'b0;
    n = 0;
    while (ready8 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_res"}, 32'(result8), 32'(exp));
    chk({tag, "_lat"}, cyc - start, 32'd10);
  endtask

  initial begin
    int          nb, n;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    valid = 1'b0; flush = 1'b0; op = '0; in_a = '0; in_b = '0;
    valid8 = 1'b0; flush8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    errors = 0;
    checks = 0;

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_result", result, 32'd0);
    rst_n = 1'b1;

    // Narrow instance
    issue8("w8_divu", 3'b101, 8'd200, 8'd3, 8'd66);
    issue8("w8_remu", 3'b111, 8'd200, 8'd3, 8'd2);
    issue8("w8_mul", 3'b000, 8'h80, 8'hFF, 8'h80);
    @(negedge clk);

    // MUL with busy-length measurement
    issue("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    nb = 0;
    n  = 0;
    while (ready !== 1'b1 && n < 100) begin
      if (busy === 1'b1) nb++;
      @(negedge clk);
      n++;
    end
    chk("mul_busy_cycles", 32'(nb), 32'd33);
    chk("busy_at_ready", 32'(busy), 32'd0);
    drain();

    issue("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    drain();
    issue("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();
    issue("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    drain();

    // Back-to-back: each new request driven in the OUT cycle of the previous
    issue("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    wait_ready();
    issue("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_ready();
    issue("divu", 3'b101, 32'd100, 32'd7, 32'h0000_000E);
    wait_ready();
    issue("remu", 3'b111, 32'd100, 32'd7, 32'h0000_0002);
    drain();

    // Divide by zero and signed overflow
    issue("div_by0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF);
    drain();
    issue("remu_by0", 3'b111, 32'd5, 32'd0, 32'h0000_0005);
    drain();
    issue("rem_neg_by0", 3'b110, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0);
    drain();
    issue("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    drain();
    issue("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    drain();

    // Random ops against the reference
    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
      if (i % 3 == 1) ra = -ra;
      issue($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, model32(ro, ra, rb));
      drain();
    end

    // valid held while busy must be ignored
    issue("busy_ignore", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    valid = 1'b1; op = 3'b000; in_a = 32'd0; in_b = 32'd0;
    repeat (20) @(negedge clk);
    valid = 1'b0;
    drain();

    // Flush at CALC cycle 10
    start_nopush(3'b101, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_result", result, 32'hFFFF_FFFE);
    repeat (40) @(negedge clk);
    chk("flush_result_hold", result, 32'hFFFF_FFFE);

    // Flush beats a simultaneous request
    valid = 1'b1; flush = 1'b1; op = 3'b000; in_a = 32'd3; in_b = 32'd3;
    @(negedge clk);
    valid = 1'b0; flush = 1'b0;
    chk("flush_valid_busy", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    chk("flush_valid_result", result, 32'hFFFF_FFFE);

    // Asynchronous reset mid-CALC
    start_nopush(3'b000, 32'd9, 32'd9);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_ready", 32'(ready), 32'd0);
    chk("async_rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue("post_rst_mul", 3'b000, 32'd6, 32'd7, 32'd42);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_div_seq.md
MUL_DIV_SEQ -- requirements
Module: mul_div_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; SHALL support any WIDTH >= 4.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 valid  input  1  request strobe; the request is accepted on a rising edge where valid=1, busy=0 and flush=0.
REQ-005 op  input  3  operation, RISC-V funct3 order: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 in_a  input  WIDTH  multiplicand/dividend (rs1).
REQ-007 in_b  input  WIDTH  multiplier/divisor (rs2).
REQ-008 flush  input  1  synchronous cancel of any in-flight operation.
REQ-009 busy  output  1  high while an accepted operation is computing.
REQ-010 ready  output  1  one-cycle pulse; result is valid in that cycle.
REQ-011 result  output  WIDTH  selected result word.

Function
REQ-012 States: IDLE, CALC, FIX, OUT; busy=1 exactly in CALC and FIX; ready=1 exactly in OUT.
REQ-013 Accept (IDLE or OUT, valid=1, flush=0): latch op; latch operand magnitudes and sign bits; clear the counter; go to CALC.
REQ-014 Signed operands: in_a is signed for MULH, MULHSU, DIV, REM; in_b is signed for MULH, DIV, REM; all others are unsigned.
REQ-015 CALC runs exactly WIDTH cycles, one shift-add (multiply) or one restoring-subtract (divide) step per cycle on magnitudes; counter wraps to 0 on the last step; then go to FIX.
REQ-016 FIX (one cycle): negate the 2*WIDTH-bit product if the product sign is set (in_a sign XOR in_b sign; in_a sign only for MULHSU); negate the quotient if the signs differ; give the remainder the sign of in_a; register result; go to OUT.
REQ-017 Selection: MUL gives the low WIDTH bits; MULH/MULHSU/MULHU give the high WIDTH bits; DIV/DIVU give the quotient; REM/REMU give the remainder.
REQ-018 Divide by zero (in_b=0): quotient all ones; remainder = in_a unmodified.
REQ-019 Signed overflow (DIV/REM, in_a = 1 followed by WIDTH-1 zeros, in_b = all ones): quotient = in_a; remainder = 0.
REQ-020 Special cases SHALL NOT shorten latency; every op takes identical latency.
REQ-021 Latency: ready SHALL be high in the cycle after the (WIDTH+1)th rising edge following the accepting edge.
REQ-022 OUT returns to IDLE unless a new request is accepted in the same cycle (back-to-back, no bubble).
REQ-023 valid while busy=1 is ignored; operands are not re-sampled.
REQ-024 result holds its value from OUT until the next FIX completes; flush and ignored requests do not alter it.
REQ-025 flush=1 in any state: next state IDLE, no ready pulse; flush wins over a simultaneous valid, and that request is dropped.
REQ-026 The accept/flush decision SHALL depend only on registered state plus valid/flush, with no combinational path from in_a/in_b to busy/ready.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, counter 0, busy=0, ready=0, result=0, and clear all operand registers, including mid-operation.
REQ-028 After rst_n rises, the first accept is possible on the first rising edge.

Verification
REQ-029 WIDTH=32. MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB; ready exactly 33 edges after accept; busy high 33 cycles.
REQ-030 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-031 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 0x0000000E; REMU -> 0x00000002; issued back-to-back during OUT with no idle cycle.
REQ-032 DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 0x00000005; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; all at normal latency.
REQ-033 flush at CALC cycle 10 -> busy=0 next cycle, no ready, result unchanged; valid held during busy is ignored; rst_n low mid-CALC -> busy/ready/result 0 without a clock edge.
REQ-034 WIDTH=8. DIVU 200/3 -> 66; REMU -> 2; MUL 0x80 x 0xFF -> 0x80; ready 9 edges after accept.
